// File: rtl/calc_arb.sv
// Round-robin arbiter that shares one in-order calc pipeline between NREQ
// requesters and routes each calc result back to the requester that issued it.
module calc_arb #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned W     = 32,
   parameter int unsigned IDW   = 2,
   parameter int unsigned DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ*W-1:0] reqA,
   input  logic [NREQ*W-1:0] reqB,
   input  logic [NREQ*W-1:0] reqC,
   input  logic [NREQ-1:0]   reqPush,
   output logic [NREQ-1:0]   reqStop,
   output logic [W-1:0]      cA,
   output logic [W-1:0]      cB,
   output logic [W-1:0]      cC,
   output logic              cPushA,
   output logic              cPushB,
   output logic              cPushC,
   input  logic              cStopA,
   input  logic              cStopB,
   input  logic              cStopC,
   input  logic [W-1:0]      cZ,
   input  logic              cPushZ,
   output logic [W-1:0]      Z,
   output logic [NREQ-1:0]   pushZ,
   output logic [IDW+2:0]    inflight,
   output logic              err
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = IDW + 3;
   localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

   logic [IDW-1:0] ptr_q,   ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [PW-1:0]  wr_q,    wr_d;
   logic [PW-1:0]  rd_q,    rd_d;
   logic [IDW-1:0] tag_q [DEPTH];
   logic [IDW-1:0] tag_d [DEPTH];
   logic [W-1:0]   ca_q, ca_d, cb_q, cb_d, cc_q, cc_d;
   logic           cpush_q, cpush_d;
   logic [W-1:0]   z_q, z_d;
   logic [NREQ-1:0] pushz_q, pushz_d;
   logic           err_q, err_d;

   logic           ok_c;
   logic           gnt_vld;
   logic [IDW-1:0] gnt_id;
   logic [IDW:0]   idx_sum;
   logic           pop_c;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Round-robin search starting at ptr; the lowest rotation distance wins
   always_comb begin
      ok_c    = (count_q < CW'(DEPTH)) & ~cStopA & ~cStopB & ~cStopC;
      gnt_vld = 1'b0;
      gnt_id  = '0;
      idx_sum = '0;
      for (int j = int'(NREQ) - 1; j >= 0; j--) begin
         idx_sum = {1'b0, ptr_q} + (IDW+1)'(j);
         if (idx_sum >= (IDW+1)'(NREQ)) begin
            idx_sum = idx_sum - (IDW+1)'(NREQ);
         end
         if (ok_c && reqPush[IDW'(idx_sum)]) begin
            gnt_vld = 1'b1;
            gnt_id  = IDW'(idx_sum);
         end
      end
   end

   // Only the granted requester is released; everyone holds while in reset
   always_comb begin
      reqStop = '1;
      if (rst && gnt_vld) begin
         reqStop[gnt_id] = 1'b0;
      end
   end

   // Next state: issue, tag FIFO push/pop, result return and occupancy
   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      tag_d   = tag_q;
      ca_d    = ca_q;
      cb_d    = cb_q;
      cc_d    = cc_q;
      cpush_d = gnt_vld;
      z_d     = z_q;
      pushz_d = '0;
      err_d   = err_q;
      pop_c   = cPushZ & (count_q != '0);

      if (gnt_vld) begin
         ca_d          = reqA[gnt_id*W +: W];
         cb_d          = reqB[gnt_id*W +: W];
         cc_d          = reqC[gnt_id*W +: W];
         tag_d[wr_q]   = gnt_id;
         wr_d          = ptr_inc(wr_q);
         ptr_d         = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
      end

      if (pop_c) begin
         z_d     = cZ;
         pushz_d = ONE_HOT0 << tag_q[rd_q];
         rd_d    = ptr_inc(rd_q);
      end else if (cPushZ) begin
         err_d = 1'b1;
      end

      case ({gnt_vld, pop_c})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q   <= '0;
         count_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         tag_q   <= '{default: '0};
         ca_q    <= '0;
         cb_q    <= '0;
         cc_q    <= '0;
         cpush_q <= 1'b0;
         z_q     <= '0;
         pushz_q <= '0;
         err_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         tag_q   <= tag_d;
         ca_q    <= ca_d;
         cb_q    <= cb_d;
         cc_q    <= cc_d;
         cpush_q <= cpush_d;
         z_q     <= z_d;
         pushz_q <= pushz_d;
         err_q   <= err_d;
      end
   end

   assign cA       = ca_q;
   assign cB       = cb_q;
   assign cC       = cc_q;
   assign cPushA   = cpush_q;
   assign cPushB   = cpush_q;
   assign cPushC   = cpush_q;
   assign Z        = z_q;
   assign pushZ    = pushz_q;
   assign inflight = count_q;
   assign err      = err_q;

endmodule

// File: tb/tb_calc_arb.sv
// Bench for calc_arb: queue-based requesters, an in-order calc model
// (Z = 17*A + 9*B) and a transaction-level reference of the arbiter.
module tb_calc_arb;

   localparam int NREQ  = 4;
   localparam int W     = 32;
   localparam int IDW   = 2;
   localparam int DEPTH = 4;
   localparam int CW    = IDW + 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ*W-1:0] reqA, reqB, reqC;
   logic [NREQ-1:0]   reqPush, reqStop;
   logic [W-1:0]      cA, cB, cC;
   logic              cPushA, cPushB, cPushC;
   logic              cStopA, cStopB, cStopC;
   logic [W-1:0]      cZ;
   logic              cPushZ;
   logic [W-1:0]      Z;
   logic [NREQ-1:0]   pushZ;
   logic [CW-1:0]     inflight;
   logic              err;

   always #5 clk = ~clk;

   calc_arb #(.NREQ(NREQ), .W(W), .IDW(IDW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .reqA(reqA), .reqB(reqB), .reqC(reqC),
      .reqPush(reqPush), .reqStop(reqStop),
      .cA(cA), .cB(cB), .cC(cC),
      .cPushA(cPushA), .cPushB(cPushB), .cPushC(cPushC),
      .cStopA(cStopA), .cStopB(cStopB), .cStopC(cStopC),
      .cZ(cZ), .cPushZ(cPushZ),
      .Z(Z), .pushZ(pushZ), .inflight(inflight), .err(err)
   );

   typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] c; } tup_t;

   tup_t         rq   [NREQ][$];   // pending tuples per requester
   logic [W-1:0] expq [NREQ][$];   // results each requester still awaits
   logic [W-1:0] calcq[$];         // calc pipeline contents
   int           tagq [$];         // reference tag FIFO

   int              m_ptr, last_g;
   bit              m_ok = 1'b0;
   logic [W-1:0]    e_ca, e_cb, e_cc, e_z, e_e2e;
   logic            e_cpush, e_err, e_e2e_v;
   logic [NREQ-1:0] e_pushz;

   int  n_cmp = 0;
   int  n_bad = 0;
   int  stop_pct = 0;
   bit  rst_req = 1'b0;

   function automatic logic [W-1:0] calc_f(input logic [W-1:0] a, input logic [W-1:0] b);
      return 17 * a + 9 * b;
   endfunction

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Which requester wins right now, from the rules alone
   function automatic int model_grant();
      if (rst !== 1'b1) return -1;
      if (tagq.size() >= DEPTH || cStopA || cStopB || cStopC) return -1;
      for (int k = 0; k < NREQ; k++) begin
         int idx;
         idx = (m_ptr + k) % NREQ;
         if (reqPush[idx]) return idx;
      end
      return -1;
   endfunction

   // Reference model update at each rising edge
   always @(posedge clk) begin
      int g, t;
      if (rst !== 1'b1) begin
         m_ptr = 0; tagq.delete(); last_g = -1;
         e_ca = '0; e_cb = '0; e_cc = '0; e_cpush = 1'b0;
         e_z = '0; e_pushz = '0; e_err = 1'b0; e_e2e_v = 1'b0;
         for (int i = 0; i < NREQ; i++) expq[i].delete();
         m_ok = 1'b1;
      end else begin
         g = model_grant();
         last_g = g;
         e_e2e_v = 1'b0;
         e_pushz = '0;
         if (g >= 0) begin
            e_ca = reqA[g*W +: W]; e_cb = reqB[g*W +: W]; e_cc = reqC[g*W +: W];
            e_cpush = 1'b1;
            m_ptr = (g + 1) % NREQ;
         end else begin
            e_cpush = 1'b0;
         end
         if (cPushZ) begin
            if (tagq.size() > 0) begin
               t = tagq.pop_front();
               e_z = cZ;
               e_pushz[t] = 1'b1;
               if (expq[t].size() > 0) begin
                  e_e2e = expq[t].pop_front();
                  e_e2e_v = 1'b1;
               end
            end else begin
               e_err = 1'b1;
            end
         end
         if (g >= 0) begin
            tagq.push_back(g);
            expq[g].push_back(calc_f(reqA[g*W +: W], reqB[g*W +: W]));
         end
      end
   end

   // Every-cycle compare, then the calc model accepts an issued tuple
   always @(negedge clk) begin
      int g;
      logic [NREQ-1:0] es;
      if (m_ok) begin
         g = model_grant();
         es = '1;
         if (g >= 0) es[g] = 1'b0;
         chk("reqStop", reqStop, es);
         chk("cPushA", cPushA, e_cpush);
         chk("cPushB", cPushB, e_cpush);
         chk("cPushC", cPushC, e_cpush);
         chk("cA", cA, e_ca);
         chk("cB", cB, e_cb);
         chk("cC", cC, e_cc);
         chk("Z", Z, e_z);
         chk("pushZ", pushZ, e_pushz);
         chk("inflight", inflight, tagq.size());
         chk("err", err, e_err);
         if (e_e2e_v && e_pushz != '0) chk("e2e_result", Z, e_e2e);
         if (rst === 1'b1 && cPushA === 1'b1) calcq.push_back(calc_f(cA, cB));
      end
   end

   // One clock of stimulus; ret: 0 none, 1 return now, 2 random return, 3 bogus result
   task automatic step(input int ret);
      @(posedge clk);
      #1;
      if (last_g >= 0) void'(rq[last_g].pop_front());
      if (rst_req) begin
         rst = 1'b0;
      end else begin
         if (!rst) calcq.delete();
         rst = 1'b1;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (rq[i].size() > 0) begin
            reqPush[i] = 1'b1;
            reqA[i*W +: W] = rq[i][0].a;
            reqB[i*W +: W] = rq[i][0].b;
            reqC[i*W +: W] = rq[i][0].c;
         end else begin
            reqPush[i] = 1'b0;
            reqA[i*W +: W] = $urandom;
            reqB[i*W +: W] = $urandom;
            reqC[i*W +: W] = $urandom;
         end
      end
      cStopA = ($urandom_range(99) < stop_pct);
      cStopB = ($urandom_range(99) < stop_pct);
      cStopC = ($urandom_range(99) < stop_pct);
      cPushZ = 1'b0;
      cZ = $urandom;
      if (!rst_req) begin
         if ((ret == 1 || (ret == 2 && $urandom_range(1) == 1)) && calcq.size() > 0) begin
            cPushZ = 1'b1;
            cZ = calcq.pop_front();
         end else if (ret == 3) begin
            cPushZ = 1'b1;
            cZ = 32'd7;
         end
      end
   endtask

   task automatic do_reset();
      rst_req = 1'b1;
      step(0);
      rst_req = 1'b0;
   endtask

   function automatic int pending();
      int n;
      n = tagq.size();
      for (int i = 0; i < NREQ; i++) n += rq[i].size();
      return n;
   endfunction

   task automatic drain();
      int k;
      k = 0;
      while (pending() > 0 && k < 300) begin
         step(2);
         k++;
      end
      if (pending() > 0) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: %0d items still pending, required 0", pending());
      end
   endtask

   task automatic wait_inflight(input int n);
      int k;
      k = 0;
      while (tagq.size() != n && k < 40) begin
         step(0);
         k++;
      end
      if (tagq.size() != n) begin
         n_cmp++; n_bad++;
         $display("FAIL wait_inflight: got %0d, required %0d", tagq.size(), n);
      end
   endtask

   function automatic tup_t rnd_tup();
      tup_t t;
      t.a = $urandom; t.b = $urandom; t.c = $urandom;
      return t;
   endfunction

   initial begin
      int   gseq[5];
      int   ng;
      bit   seen2;
      tup_t t;

      rst = 1'b0; reqPush = '0; reqA = '0; reqB = '0; reqC = '0;
      cStopA = 1'b0; cStopB = 1'b0; cStopC = 1'b0; cPushZ = 1'b0; cZ = '0;
      last_g = -1;

      // Reset state
      rst_req = 1'b1;
      step(0);
      step(0);
      @(negedge clk);
      chk("rst_inflight", inflight, 0);
      chk("rst_err", err, 0);
      chk("rst_pushZ", pushZ, 0);
      chk("rst_cPushA", cPushA, 0);
      chk("rst_reqStop", reqStop, 4'b1111);
      rst_req = 1'b0;

      // Single request
      rq[0].push_back('{a: 1, b: 2, c: 3});
      step(0);
      @(negedge clk);
      chk("single_stop", reqStop, 4'b1110);
      step(0);
      @(negedge clk);
      chk("single_cpush", {cPushA, cPushB, cPushC}, 3'b111);
      chk("single_cA", cA, 1);
      chk("single_cB", cB, 2);
      chk("single_cC", cC, 3);
      step(1);
      step(0);
      @(negedge clk);
      chk("single_Z", Z, 35);
      chk("single_pushZ", pushZ, 4'b0001);

      // Round-robin fairness from a fresh pointer
      do_reset();
      for (int i = 0; i < NREQ; i++)
         for (int k = 0; k < 3; k++)
            rq[i].push_back((i == 2) ? '{a: 2, b: 1, c: 1} : rnd_tup());
      ng = 0;
      seen2 = 1'b0;
      for (int n = 0; n < 80; n++) begin
         step(2);
         @(negedge clk);
         if (reqStop != 4'hF && ng < 5) begin
            for (int i = 0; i < NREQ; i++) if (!reqStop[i]) gseq[ng] = i;
            ng++;
         end
         if (pushZ[2] && !seen2) begin
            chk("rr_z2", Z, 43);
            chk("rr_pushZ2", pushZ, 4'b0100);
            seen2 = 1'b1;
         end
      end
      chk("rr_count", ng, 5);
      chk("rr_g0", gseq[0], 0);
      chk("rr_g1", gseq[1], 1);
      chk("rr_g2", gseq[2], 2);
      chk("rr_g3", gseq[3], 3);
      chk("rr_g4", gseq[4], 0);
      chk("rr_seen2", seen2, 1);
      drain();

      // Full FIFO blocks grants; one pop re-enables them a cycle later
      for (int i = 0; i < NREQ; i++)
         for (int k = 0; k < 2; k++) rq[i].push_back(rnd_tup());
      wait_inflight(DEPTH);
      @(negedge clk);
      chk("full_inflight", inflight, 4);
      chk("full_stop", reqStop, 4'b1111);
      step(1);
      @(negedge clk);
      chk("full_hold", reqStop, 4'b1111);
      step(0);
      @(negedge clk);
      chk("full_after_pop", inflight, 3);
      chk("full_resume", (reqStop != 4'hF), 1);
      drain();

      // Grant and result return on the same edge
      rq[1].push_back('{a: 3, b: 4, c: 5});
      rq[1].push_back('{a: 10, b: 0, c: 0});
      wait_inflight(2);
      rq[2].push_back('{a: 5, b: 6, c: 7});
      step(1);
      step(0);
      @(negedge clk);
      chk("sim_inflight", inflight, 2);
      chk("sim_pushZ", pushZ, 4'b0010);
      chk("sim_Z", Z, 87);
      step(1);
      step(0);
      @(negedge clk);
      chk("sim_Z2", Z, 170);
      chk("sim_pushZ2", pushZ, 4'b0010);
      step(1);
      step(0);
      @(negedge clk);
      chk("sim_Z3", Z, 139);
      chk("sim_pushZ3", pushZ, 4'b0100);
      chk("sim_empty", inflight, 0);
      drain();

      // Result with no tag
      step(3);
      step(0);
      @(negedge clk);
      chk("unexp_pushZ", pushZ, 0);
      chk("unexp_err", err, 1);
      chk("unexp_inflight", inflight, 0);
      step(0);
      step(0);
      @(negedge clk);
      chk("unexp_sticky", err, 1);

      // Reset with three tuples in flight
      rq[0].push_back(rnd_tup());
      rq[1].push_back(rnd_tup());
      rq[2].push_back(rnd_tup());
      wait_inflight(3);
      do_reset();
      @(negedge clk);
      chk("mr_stop_in_rst", reqStop, 4'b1111);
      rq[1].push_back(rnd_tup());
      rq[3].push_back(rnd_tup());
      step(0);
      @(negedge clk);
      chk("mr_inflight", inflight, 0);
      chk("mr_err", err, 0);
      chk("mr_pushZ", pushZ, 0);
      chk("mr_cPushA", cPushA, 0);
      chk("mr_Z", Z, 0);
      chk("mr_cA", cA, 0);
      chk("mr_first_grant", reqStop, 4'b1101);
      drain();

      // Randomized traffic with calc stalls
      stop_pct = 20;
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(2) != 0) begin
            t = rnd_tup();
            ng = $urandom_range(NREQ - 1);
            if (rq[ng].size() < 4) rq[ng].push_back(t);
         end
         if (n == 700) do_reset();
         else step(2);
      end
      stop_pct = 0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/calc_arb.md
Name: calc_arb

Overview:
- Round-robin arbiter and scheduler that shares one calc pipeline between NREQ requesters.
- Each requester offers a complete {A,B,C} tuple using push/stop.
- The arbiter issues at most one tuple per cycle to calc, with all three operand pushes asserted together.
- It records the requester ID of every issued tuple in an in-order tag FIFO, then returns each calc result to its originating requester.

Parameters:
- NREQ, 4, number of requesters.
- W, 32, operand and result width.
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ.
- DEPTH, 16, tag FIFO depth, which is the maximum number of tuples in flight; must be >= calc latency for full throughput.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low. rst=0 at a rising edge of clk resets the block.
- reqA  in  NREQ*W  requester A operands; requester i uses bits [i*W +: W]. reqB and reqC use the same layout.
- reqB  in  NREQ*W  requester B operands.
- reqC  in  NREQ*W  requester C operands.
- reqPush  in  NREQ  requester i offers a valid tuple.
- reqStop  out  NREQ  requester i must hold its tuple this cycle.
- cA, cB, cC  out  W each  operands driven to calc.
- cPushA, cPushB, cPushC  out  1 each  operand pushes to calc; always asserted together.
- cStopA, cStopB, cStopC  in  1 each  stops from calc.
- cZ  in  W  calc result.
- cPushZ  in  1  calc result valid.
- Z  out  W  returned result.
- pushZ  out  NREQ  one-hot; bit i set means Z belongs to requester i.
- inflight  out  IDW+3 (wide enough for 0..DEPTH)  current tag FIFO occupancy.
- err  out  1  sticky; a result arrived with no tag.

Behaviour:
- Reset (rst=0 at clk edge):
  - All outputs become 0; reqStop is all ones while in reset.
  - Round-robin pointer = 0, FIFO empty, err = 0.
  - calc is reset with the same strobe. A reset mid-operation discards all in-flight tags.
- Grant condition (combinational): eligible = reqPush & {NREQ{ok}}, where ok = (inflight < DEPTH) & ~cStopA & ~cStopB & ~cStopC.
  - grant = first eligible index searching ptr, ptr+1, …, wrapping modulo NREQ.
  - reqStop[i] = ~(grant valid & grant==i).
- Transfer rule: requester i transfers on a cycle with reqPush[i]=1 and reqStop[i]=0. The requester must hold its data stable while reqStop[i]=1.
- Issue (registered, 1 cycle after the transfer):
  - cA/cB/cC <= the granted requester's operands; cPushA/B/C <= 1 for exactly one cycle.
  - With no grant, cPush* <= 0 and the operands hold their previous values.
- On a grant:
  - The grant ID is written to the tail of the tag FIFO.
  - ptr <= (grant+1) mod NREQ.
  - With no grant, ptr is unchanged.
- Throughput: back-to-back grants on consecutive cycles are legal; the issue rate is one tuple per cycle.
- Result return (registered, 1 cycle after cPushZ):
  - The head tag is popped; Z <= cZ; pushZ <= one-hot(head tag) for one cycle.
  - With no cPushZ, pushZ = 0 and Z holds its previous value.
- Occupancy:
  - Grant and cPushZ in the same cycle: inflight unchanged; write and pop both occur.
  - Grant only: +1. cPushZ only: −1.
- Full: inflight==DEPTH blocks all grants (all reqStop=1). A cPushZ in that same cycle still pops, but the grant is not re-enabled until the following cycle, because ok uses the registered count.
- Empty with cPushZ: the result is dropped, pushZ stays 0, err <= 1 and stays set until reset, and inflight stays 0 (no underflow).
- Ordering: calc is in-order, so results return in issue order. A requester receives its results in the order it submitted them.
- Wrap-around:
  - FIFO read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - ptr wraps from NREQ−1 to 0.
- Calc stop asserted: no grants while any cStop* is high; pending requesters simply hold.

Test Plan:
- Single request: requester 0 presents A=1, B=2, C=3.
  - Expect reqStop[0]=0 the same cycle, then cPushA/B/C=1 with cA=1, cB=2, cC=3 one cycle later.
  - When the calc result returns: Z=35, pushZ=4'b0001.
- Round-robin fairness: all 4 requesters hold reqPush=1 continuously.
  - Grants follow 0,1,2,3,0,…
  - Requester 2 sends A=2, B=1, C=1; it receives Z=43 with pushZ=4'b0100, in order among the returned results.
- Full: DEPTH=4 with cPushZ held off.
  - After 4 grants, inflight=4 and reqStop=4'b1111.
  - One cPushZ pops, inflight becomes 3, and a grant resumes on the next cycle.
- Simultaneous grant and cPushZ at inflight=2:
  - inflight stays 2.
  - The returned tag is the oldest; the new tag is appended at the tail.
- Unexpected result: with the FIFO empty, pulse cPushZ with cZ=7.
  - pushZ stays 0, err=1 and remains set; inflight stays 0.
- Reset mid-flight: with 3 tuples in flight, drive rst=0 for one edge.
  - Expect inflight=0, ptr=0, err=0, all outputs 0.
  - The next grant goes to the lowest-indexed active requester.
